// File: rtl/prng_engine.sv
// Multi-mode pseudo-random engine: an LCG with an iterative shift-add multiply, or a Galois LFSR.
// Optional output tempering is enabled by defining PRNG_TEMPER_EN.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for req; req_ready high unless load_seed
// MUL    | LCG shift-add multiply, one multiplier bit per cycle
// ADD    | LCG state <= acc + C
// STEP   | one Galois LFSR step (reloads SEED from the all-zero state)
// HOLD   | rnd_out valid, waiting for rnd_ready
module prng_engine #(
  parameter int unsigned WIDTH = 32,
  parameter logic [31:0] A     = 32'd1103515245,
  parameter logic [31:0] C     = 32'd12345,
  parameter logic [31:0] TAPS  = 32'h80200003,
  parameter logic [31:0] SEED  = 32'h1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_seed,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  output logic             req_ready,
  input  logic             mode,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic [WIDTH-1:0] rnd_out,
  output logic             rnd_bit,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [WIDTH-1:0] A_W    = WIDTH'(A);
  localparam logic [WIDTH-1:0] C_W    = WIDTH'(C);
  localparam logic [WIDTH-1:0] TAPS_W = WIDTH'(TAPS);
  localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_ADD  = 3'd2,
    S_STEP = 3'd3,
    S_HOLD = 3'd4
  } fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= S_IDLE;
      state_q  <= SEED_W;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // The multiplicand shifts left while the multiplier shifts right, so adding
  // mcand_q on each set multiplier bit is acc += multiplicand << bit_index.
  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;

    if (load_seed) begin
      state_d = seed_in;
      fsm_d   = S_IDLE;
    end else begin
      unique case (fsm_q)
        S_IDLE: begin
          if (req) begin
            if (mode) begin
              fsm_d = S_STEP;
            end else begin
              mcand_d  = state_q;
              mplier_d = A_W;
              acc_d    = '0;
              cnt_d    = CNT_LAST;
              fsm_d    = S_MUL;
            end
          end
        end
        S_MUL: begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (cnt_q == '0) begin
            fsm_d = S_ADD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_ADD: begin
          state_d = acc_q + C_W;
          fsm_d   = S_HOLD;
        end
        S_STEP: begin
          if (state_q == '0) begin
            state_d = SEED_W;
          end else begin
            state_d = (state_q >> 1) ^ (state_q[0] ? TAPS_W : '0);
          end
          fsm_d = S_HOLD;
        end
        S_HOLD: begin
          if (rnd_ready) begin
            fsm_d = S_IDLE;
          end
        end
        default: begin
          fsm_d = S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = (fsm_q == S_IDLE) & ~load_seed;
  assign rnd_valid = (fsm_q == S_HOLD);
  assign busy      = (fsm_q != S_IDLE);

`ifdef PRNG_TEMPER_EN
  assign rnd_out = state_q ^ (state_q >> (WIDTH / 2));
`else
  assign rnd_out = state_q;
`endif

  assign rnd_bit = rnd_out[0];

endmodule
